// File: rtl/div64x32.sv
// Sequential unsigned 64/32 restoring divider, STEPS_PER_CYCLE quotient bits per clock, start/busy handshake.
// Optional DIV_ZERO_SKIP_EN: a zero dividend finishes on the sampling edge instead of running CALC.
module div64x32 #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero,
    output logic        overflow
);

    localparam int ITER = 32 / STEPS_PER_CYCLE;
    localparam int CW   = $clog2(ITER);

    typedef enum logic {IDLE, CALC} state_t;

    state_t        state;
    logic [31:0]   prem;
    logic [31:0]   shreg;
    logic [31:0]   dvs;
    logic [CW-1:0] cnt;
    logic [31:0]   step_rem;
    logic [31:0]   step_sh;
    logic [32:0]   trial;
    logic          skip_zero;

`ifdef DIV_ZERO_SKIP_EN
    assign skip_zero = (dividend == 64'd0);
`else
    assign skip_zero = 1'b0;
`endif

    // shreg shifts dividend bits out at the top while quotient bits enter at the bottom;
    // the trial value is 33 bits because the shifted partial remainder can exceed 2^32-1
    always_comb begin
        step_rem = prem;
        step_sh  = shreg;
        trial    = '0;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            trial   = {step_rem, step_sh[31]};
            step_sh = {step_sh[30:0], 1'b0};
            if (trial >= {1'b0, dvs}) begin
                trial      = trial - {1'b0, dvs};
                step_sh[0] = 1'b1;
            end
            step_rem = trial[31:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            prem        <= '0;
            shreg       <= '0;
            dvs         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        dvs         <= divisor;
                        if (divisor == 32'd0) begin
                            quotient    <= '1;
                            remainder   <= dividend[31:0];
                            div_by_zero <= 1'b1;
                        end else if (dividend[63:32] >= divisor) begin
                            quotient  <= '1;
                            remainder <= '0;
                            overflow  <= 1'b1;
                        end else if (skip_zero) begin
                            quotient  <= '0;
                            remainder <= '0;
                        end else begin
                            prem  <= dividend[63:32];
                            shreg <= dividend[31:0];
                            cnt   <= CW'(ITER - 1);
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem  <= step_rem;
                    shreg <= step_sh;
                    cnt   <= cnt - CW'(1);
                    if (cnt == '0) begin
                        quotient  <= step_sh;
                        remainder <= step_rem;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/div64x32.md
Name: div64x32

Overview:
- Sequential unsigned divider: 64-bit dividend by 32-bit divisor, producing a 32-bit quotient and a 32-bit remainder.
- Inverse companion of the 32x32 sequential multiplier; uses the same start/busy handshake so one controller can drive either unit.
- Restoring shift-subtract algorithm, STEPS_PER_CYCLE quotient bits per clock.

Parameters:
- STEPS_PER_CYCLE, 1, quotient bits resolved per clock. Legal values: 1, 2, 4. ITER = 32/STEPS_PER_CYCLE.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled on the rising edge only while busy=0.
- dividend  input  64  unsigned dividend; sampled with start.
- divisor  input  32  unsigned divisor; sampled with start.
- busy  output  1  division in progress.
- quotient  output  32  result quotient.
- remainder  output  32  result remainder.
- div_by_zero  output  1  last accepted operation had divisor==0.
- overflow  output  1  last accepted operation's quotient exceeds 32 bits.

Behaviour:
- Reset is asynchronous and active-high. While reset=1: busy=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, state=IDLE. Asserting reset mid-operation aborts and discards the operation.
- FSM states: IDLE, CALC.
- IDLE, rising edge with start=1:
  - Operands are latched.
  - div_by_zero and overflow are cleared.
  - Outcome is selected by the operand checks below.
- Operand checks, evaluated on the sampling edge:
  - divisor==0: quotient=32'hFFFF_FFFF, remainder=dividend[31:0], div_by_zero=1. busy stays 0; remain in IDLE.
  - else dividend[63:32] >= divisor: quotient=32'hFFFF_FFFF, remainder=0, overflow=1. busy stays 0; remain in IDLE.
  - else: busy=1 from this edge; go to CALC. Partial remainder = dividend[63:32]; shift register = dividend[31:0].
- CALC step (repeated STEPS_PER_CYCLE times per edge, chained combinationally):
  - Form a 33-bit value: {partial remainder, next dividend bit}.
  - If it is >= divisor: subtract divisor and shift in quotient bit 1; otherwise shift in 0.
  - The 33-bit width is mandatory; the partial remainder before the shift can be as large as divisor-1 = 2^32-2.
- CALC completes after exactly ITER edges:
  - On the final edge, quotient and remainder are written, busy goes to 0, and the FSM returns to IDLE.
  - busy is high for exactly ITER cycles (32 when STEPS_PER_CYCLE=1).
- Output visibility:
  - quotient and remainder hold their previous values throughout CALC.
  - New values appear only on the edge where busy falls and are held until the next accepted start.
- start while busy=1 is ignored and has no effect on the in-flight operation.
- start may be asserted in the first cycle after busy falls (back-to-back operations; no dead cycle).
- Result invariant for every non-flagged operation: dividend == quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
- Macro: DIV_ZERO_SKIP_EN.
- Defined: a non-flagged start with dividend==0 completes on the sampling edge. quotient=0, remainder=0, busy never asserts.
- Undefined: dividend==0 takes the normal ITER-cycle CALC path and yields quotient=0, remainder=0.
- All other behaviour is identical in both builds.

Test Plan:
- Reset held 8 time units, then dividend=64'd100, divisor=32'd7, start for one cycle -> busy high exactly 32 cycles; then quotient=32'd14, remainder=32'd2, both flags 0.
- dividend=64'hFFFF_FFFE_0000_0001, divisor=32'hFFFF_FFFF -> quotient=32'hFFFF_FFFF, remainder=0 (exercises the 33-bit compare).
- divisor=0, dividend=64'h1234_5678_9ABC_DEF0 -> busy never rises; div_by_zero=1, quotient=32'hFFFF_FFFF, remainder=32'h9ABC_DEF0. Next valid start clears div_by_zero.
- dividend=64'h0000_0005_0000_0000, divisor=5 -> overflow=1, quotient=32'hFFFF_FFFF, remainder=0, busy stays 0.
- Mid-operation behaviour, dividend=64'h1_0000_0000, divisor=2:
  - Pulse start again at cycle 5 of busy -> ignored; result quotient=32'h8000_0000, remainder=0.
  - Repeat, asserting reset at cycle 10 -> busy=0 and all outputs 0 immediately (asynchronous).
- With DIV_ZERO_SKIP_EN: dividend=0, divisor=3 -> busy stays 0, quotient=0, remainder=0. Without it: busy high 32 cycles, same result.
